// File: rtl/mat_pkg.sv
// mat_pkg: shared sizes, drain state and row-slice helper for the row-serial matrix stages
package mat_pkg;
  localparam int DATA_LEN = 32;
  localparam int M = 8;
  localparam int K = 8;
  localparam int ROW_SIZE = DATA_LEN * K;
  localparam int MAT_SIZE = DATA_LEN * K * M;
  localparam int IDX_W = (M > 1) ? $clog2(M) : 1;
  typedef enum logic {IDLE, STREAM} drain_state_t;
  function automatic logic [ROW_SIZE-1:0] row_slice(input logic [MAT_SIZE-1:0] mat, input int unsigned r);
    return mat[ROW_SIZE*r +: ROW_SIZE];
  endfunction
endpackage

// File: rtl/mat_row_sel.sv
// mat_row_sel: combinational M:1 row mux over a packed matrix, selected by row index
module mat_row_sel #(
  parameter int ROW_SIZE = 256,
  parameter int M = 8,
  parameter int IDX_W = 3
) (
  input  logic [ROW_SIZE*M-1:0] mat,
  input  logic [IDX_W-1:0]      sel,
  output logic [ROW_SIZE-1:0]   row
);
  assign row = mat[ROW_SIZE*sel +: ROW_SIZE];
endmodule

// File: rtl/mat_row_drain.sv
// mat_row_drain: captures the accumulator matrix on i_done and streams it one row per valid/ready handshake
// MAT_ROW_DRAIN_RELU_EN clamps negative elements to 0 on the capture path.
module mat_row_drain
  import mat_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_done,
  input  logic [MAT_SIZE-1:0] i_mat,
  output logic                o_can_accept,
  output logic                o_row_valid,
  input  logic                i_row_ready,
  output logic [ROW_SIZE-1:0] o_row,
  output logic [IDX_W-1:0]    o_row_idx,
  output logic                o_row_last,
  output logic                o_drop,
  output logic                o_busy
);
  drain_state_t state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [MAT_SIZE-1:0] mat_q, cap_mat;
  logic [ROW_SIZE-1:0] sel_row;
  logic busy, hs, cap, done_last;
`ifdef MAT_ROW_DRAIN_RELU_EN
  always_comb begin
    cap_mat = i_mat;
    for (int e = 0; e < M*K; e++)
      if (i_mat[DATA_LEN*e + DATA_LEN-1]) cap_mat[DATA_LEN*e +: DATA_LEN] = '0;
  end
`else
  assign cap_mat = i_mat;
`endif
  mat_row_sel #(.ROW_SIZE(ROW_SIZE), .M(M), .IDX_W(IDX_W)) u_sel (
    .mat(mat_q),
    .sel(ptr),
    .row(sel_row)
  );
  // accept while idle, or when the last row leaves this very cycle
  always_comb begin
    busy = state == STREAM;
    o_row_last = busy && ptr == IDX_W'(M-1);
    hs = busy && i_row_ready;
    done_last = hs && o_row_last;
    o_can_accept = !busy || (o_row_last && i_row_ready);
    cap = i_done && o_can_accept;
    state_n = cap ? STREAM : done_last ? IDLE : state;
    ptr_n = (cap || done_last) ? '0 : hs ? ptr + 1'b1 : ptr;
    o_busy = busy;
    o_row_valid = busy;
    o_row_idx = ptr;
    o_row = busy ? sel_row : '0;
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= IDLE;
      ptr <= '0;
      mat_q <= '0;
      o_drop <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      if (cap) mat_q <= cap_mat;
      if (i_done && !o_can_accept) o_drop <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mat_row_drain.sv
// tb_mat_row_drain: scoreboard bench for mat_row_drain; expected rows queued at i_done, checked by a monitor
module tb_mat_row_drain;
  import mat_pkg::*;
  localparam int W = ROW_SIZE;
  typedef struct {
    logic [IDX_W-1:0] idx;
    logic last;
    logic [ROW_SIZE-1:0] row;
  } exp_t;
  logic i_clk = 0, i_rstn, i_done, i_row_ready;
  logic [MAT_SIZE-1:0] i_mat;
  logic o_can_accept, o_row_valid, o_row_last, o_drop, o_busy;
  logic [ROW_SIZE-1:0] o_row;
  logic [IDX_W-1:0] o_row_idx;
  exp_t sbq[$];
  int n_vec = 0, n_err = 0;
  mat_row_drain dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_done(i_done), .i_mat(i_mat),
    .o_can_accept(o_can_accept), .o_row_valid(o_row_valid), .i_row_ready(i_row_ready),
    .o_row(o_row), .o_row_idx(o_row_idx), .o_row_last(o_row_last),
    .o_drop(o_drop), .o_busy(o_busy)
  );
  always #5 i_clk = ~i_clk;
  task automatic check(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask
  function automatic logic [31:0] exp_el(input int v);
`ifdef MAT_ROW_DRAIN_RELU_EN
    return v < 0 ? 32'd0 : 32'(v);
`else
    return 32'(v);
`endif
  endfunction
  function automatic logic [MAT_SIZE-1:0] make_mat(input int base);
    logic [MAT_SIZE-1:0] m = '0;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < K; c++) m[ROW_SIZE*r + DATA_LEN*c +: DATA_LEN] = 32'(base + r*K + c);
    return m;
  endfunction
  function automatic logic [ROW_SIZE-1:0] exp_row(input int base, input int r);
    logic [ROW_SIZE-1:0] row = '0;
    for (int c = 0; c < K; c++) row[DATA_LEN*c +: DATA_LEN] = exp_el(base + r*K + c);
    return row;
  endfunction
  task automatic push_rows(input int base, input int n);
    for (int r = 0; r < n; r++) sbq.push_back('{IDX_W'(r), r == M-1, exp_row(base, r)});
  endtask
  task automatic drain(input logic bp);
    int cyc = 0;
    while (o_busy && cyc < 100) begin
      i_row_ready = bp ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      @(posedge i_clk); #1;
      cyc++;
    end
    check("drain_timeout", W'(o_busy), W'(0));
  endtask
  task automatic pulse(input int base, input int n, input logic rdy);
    i_mat = make_mat(base);
    i_done = 1;
    i_row_ready = rdy;
    push_rows(base, n);
    @(posedge i_clk); #1;
    i_done = 0;
  endtask
  // monitor: pops on every handshake and checks that stalled rows hold
  initial begin
    logic prev_stall = 0;
    logic [ROW_SIZE-1:0] p_row = '0;
    logic [IDX_W-1:0] p_idx = '0;
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (!i_rstn) prev_stall = 0;
      else begin
        if (prev_stall) begin
          check("hold_valid", W'(o_row_valid), W'(1));
          check("hold_row", o_row, p_row);
          check("hold_idx", W'(o_row_idx), W'(p_idx));
        end
        if (o_row_valid && i_row_ready) begin
          if (sbq.size() == 0) check("sb_underflow", W'(sbq.size()), W'(1));
          else begin
            e = sbq.pop_front();
            check("row_idx", W'(o_row_idx), W'(e.idx));
            check("row_last", W'(o_row_last), W'(e.last));
            check("row_data", o_row, e.row);
          end
        end
        prev_stall = o_row_valid && !i_row_ready;
        p_row = o_row;
        p_idx = o_row_idx;
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    i_rstn = 0; i_done = 0; i_mat = '0; i_row_ready = 0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_valid", W'(o_row_valid), W'(0));
    check("rst_row", o_row, W'(0));
    check("rst_idx", W'(o_row_idx), W'(0));
    check("rst_last", W'(o_row_last), W'(0));
    check("rst_drop", W'(o_drop), W'(0));
    check("rst_busy", W'(o_busy), W'(0));
    check("rst_accept", W'(o_can_accept), W'(1));
    i_rstn = 1;
    @(posedge i_clk); #1;
    i_mat = make_mat(0); i_done = 1; i_row_ready = 1;
    push_rows(0, M);
    @(negedge i_clk);
    check("lat_pre", W'(o_row_valid), W'(0));
    @(posedge i_clk); #1;
    i_done = 0;
    check("lat_post", W'(o_row_valid), W'(1));
    check("lat_idx", W'(o_row_idx), W'(0));
    drain(0);
    check("idle_accept", W'(o_can_accept), W'(1));
    pulse(100, M, 1);
    drain(1);
    pulse(200, M, 1);
    for (int i = 0; i < 20 && !o_row_last; i++) begin @(posedge i_clk); #1; end
    check("b2b_last", W'(o_row_last), W'(1));
    check("b2b_accept", W'(o_can_accept), W'(1));
    pulse(300, M, 1);
    check("b2b_valid", W'(o_row_valid), W'(1));
    check("b2b_idx", W'(o_row_idx), W'(0));
    check("b2b_drop", W'(o_drop), W'(0));
    drain(0);
    pulse(400, M, 0);
    i_row_ready = 1;
    repeat (3) begin @(posedge i_clk); #1; end
    i_row_ready = 0;
    check("drop_idx", W'(o_row_idx), W'(3));
    check("drop_accept", W'(o_can_accept), W'(0));
    i_mat = make_mat(500); i_done = 1;
    @(posedge i_clk); #1;
    i_done = 0;
    check("drop_set", W'(o_drop), W'(1));
    check("drop_idx_hold", W'(o_row_idx), W'(3));
    drain(0);
    check("drop_sticky", W'(o_drop), W'(1));
    pulse(-10, M, 1);
    drain(0);
    pulse(600, 4, 0);
    i_row_ready = 1;
    repeat (4) begin @(posedge i_clk); #1; end
    i_row_ready = 0;
    check("mid_idx", W'(o_row_idx), W'(4));
    i_rstn = 0;
    #1;
    check("mid_valid", W'(o_row_valid), W'(0));
    check("mid_row", o_row, W'(0));
    check("mid_ridx", W'(o_row_idx), W'(0));
    check("mid_busy", W'(o_busy), W'(0));
    check("mid_drop", W'(o_drop), W'(0));
    check("mid_accept", W'(o_can_accept), W'(1));
    @(posedge i_clk); #1;
    i_rstn = 1;
    @(posedge i_clk); #1;
    pulse(700, M, 1);
    check("post_valid", W'(o_row_valid), W'(1));
    check("post_idx", W'(o_row_idx), W'(0));
    drain(0);
    @(negedge i_clk);
    check("sb_empty", W'(sbq.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
